// File: rtl/spi_transaction_fsm.sv
// Transaction sequencer for the SPI memory slave: address, R/W bit, then 8 data bits in or out.
// Optional SCLK-idle watchdog is enabled by defining SPI_TIMEOUT_EN.
module spi_transaction_fsm #(
  parameter int unsigned addrwidth     = 7,
  parameter int unsigned datawidth     = 8,
  parameter int unsigned timeoutcycles = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_cond,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_buff,
  output logic busy,
  output logic abort
);

  localparam int unsigned CntW = $clog2(addrwidth + datawidth + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StLatchAddr,
    StReadLoad,
    StReadShift,
    StWriteRecv,
    StWriteCommit,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            addr_we_d, sr_we_d, dm_we_d, miso_buff_d, busy_d, abort_d;
  logic            start_ok;
  logic            in_xfer;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(timeoutcycles + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             lock_q, lock_d;
  logic             expired;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
    in_xfer     = (state_q != StIdle) && (state_q != StDone);
`ifdef SPI_TIMEOUT_EN
    lock_d      = lock_q;
    start_ok    = !lock_q;
    expired     = ((state_q == StGetAddr) || (state_q == StReadShift) ||
                   (state_q == StWriteRecv)) && !sclk_pos && !sclk_neg &&
                  (wdog_q == WdogW'(timeoutcycles - 1));
`else
    start_ok    = 1'b1;
`endif

    unique case (state_q)
      StIdle: begin
        if (!cs_cond && start_ok) state_d = StGetAddr;
      end
      StGetAddr: begin
        if (sclk_pos) begin
          if (cnt_q == CntW'(addrwidth)) state_d = StLatchAddr;
          else                           cnt_d   = cnt_q + CntW'(1);
        end
      end
      StLatchAddr:   state_d = rw_bit ? StReadLoad : StWriteRecv;
      StReadLoad:    state_d = StReadShift;
      StReadShift: begin
        if (sclk_neg) begin
          if (cnt_q == CntW'(datawidth - 1)) state_d = StDone;
          else                               cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWriteRecv: begin
        if (sclk_pos) begin
          if (cnt_q == CntW'(datawidth - 1)) state_d = StWriteCommit;
          else                               cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWriteCommit: state_d = StDone;
      StDone: begin
        if (cs_cond) state_d = StIdle;
      end
      default:       state_d = StIdle;
    endcase

    // Premature CS release overrides whatever the transaction wanted to do.
    if (cs_cond && in_xfer) begin
      state_d = StIdle;
      abort_d = 1'b1;
    end
`ifdef SPI_TIMEOUT_EN
    else if (expired) begin
      state_d = StIdle;
      abort_d = 1'b1;
      lock_d  = 1'b1;
    end
    if (state_q == StIdle && cs_cond) lock_d = 1'b0;

    if (sclk_pos || sclk_neg || (state_q != StGetAddr && state_d == StGetAddr)) begin
      wdog_d = '0;
    end else if (wdog_q != WdogW'(timeoutcycles)) begin
      wdog_d = wdog_q + WdogW'(1);
    end else begin
      wdog_d = wdog_q;
    end
`endif

    if (state_d != state_q) cnt_d = '0;

    addr_we_d   = (state_d == StLatchAddr);
    sr_we_d     = (state_d == StReadLoad);
    dm_we_d     = (state_d == StWriteCommit);
    miso_buff_d = (state_d == StReadShift);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_we   <= 1'b0;
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      miso_buff <= 1'b0;
      busy      <= 1'b0;
      abort     <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      wdog_q    <= '0;
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_we   <= addr_we_d;
      sr_we     <= sr_we_d;
      dm_we     <= dm_we_d;
      miso_buff <= miso_buff_d;
      busy      <= busy_d;
      abort     <= abort_d;
`ifdef SPI_TIMEOUT_EN
      wdog_q    <= wdog_d;
      lock_q    <= lock_d;
`endif
    end
  end

endmodule

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
- Sequencing controller for the SPI memory slave datapath.
- Consumes the conditioned chip-select level and the one-cycle SCLK edge pulses produced by the input conditioners.
- Drives the write-enables for the address latch, data memory and shift-register parallel load, plus the MISO tristate buffer enable.
- One transaction: 7-bit address, then 1 R/W bit, then 8 data bits out (read) or in (write).

Parameters:
- addrwidth, 7, address bits shifted in before the R/W bit.
- datawidth, 8, data bits per transfer.
- timeoutcycles, 255, idle-SCLK abort threshold in clk cycles (used only with SPI_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cs_cond  input  1  conditioned chip select, active low.
- sclk_pos  input  1  one-cycle pulse at each conditioned SCLK rising edge.
- sclk_neg  input  1  one-cycle pulse at each conditioned SCLK falling edge.
- rw_bit  input  1  shift-register parallel-out bit 0 (1 = read, 0 = write).
- addr_we  output  1  one-cycle pulse latching the address from the shift register.
- sr_we  output  1  one-cycle pulse parallel-loading the shift register from data memory.
- dm_we  output  1  one-cycle pulse writing the shift-register contents to data memory.
- miso_buff  output  1  MISO tristate enable; high only while read data shifts out.
- busy  output  1  high whenever state is not IDLE.
- abort  output  1  one-cycle pulse on premature CS deassert (or timeout).

Behaviour:
- Reset: reset=1 at a posedge puts state in IDLE, bit counter at 0, and every output at 0. Reset has priority over all other inputs.
- Registered outputs: all outputs come from registers and are valid the cycle after the state change.
- Bit counter: width clog2(addrwidth+datawidth+1). Cleared on every state transition.
- CS priority: cs_cond=1 in any state other than IDLE/DONE sends the next state to IDLE and pulses abort for 1 cycle. No dm_we, addr_we or sr_we fires in that cycle.
- IDLE: cs_cond=0 moves to GET_ADDR. All SCLK pulses are ignored.
- GET_ADDR: counts sclk_pos pulses. When addrwidth+1 pulses are reached (8 by default, the 8th being R/W), moves to LATCH_ADDR.
- LATCH_ADDR (1 cycle): addr_we=1. Samples rw_bit. rw_bit=1 moves to READ_LOAD; rw_bit=0 moves to WRITE_RECV.
- READ_LOAD (1 cycle): sr_we=1, then moves to READ_SHIFT.
- READ_SHIFT: miso_buff=1. Counts sclk_neg pulses. After datawidth pulses, moves to DONE, and miso_buff drops in the same cycle DONE is entered.
- WRITE_RECV: counts sclk_pos pulses. After datawidth pulses, moves to WRITE_COMMIT.
- WRITE_COMMIT (1 cycle): dm_we=1, then moves to DONE.
- DONE: all enables 0. Extra SCLK pulses are ignored. cs_cond=1 moves to IDLE with no abort pulse.
- Counting discipline: only the edge type relevant to the current state is counted. sclk_pos and sclk_neg asserted together is illegal upstream; the FSM counts only the relevant one.
- Pulse widths: addr_we, sr_we and dm_we are each exactly 1 cycle per transaction and are mutually exclusive.
- Back-to-back: CS low again in the cycle after returning to IDLE starts a new transaction normally.

Optional Feature:
SPI_TIMEOUT_EN
- Defined: a watchdog counter (width clog2(timeoutcycles+1)) clears on any sclk_pos or sclk_neg and on entering GET_ADDR. In GET_ADDR, READ_SHIFT or WRITE_RECV, reaching timeoutcycles cycles with no SCLK pulse forces IDLE and pulses abort. After a timeout, IDLE waits for cs_cond=1 before accepting a new CS-low.
- Undefined: no watchdog logic; the FSM waits indefinitely; timeoutcycles is unused.

Test Plan:
- Write: reset, CS low, 8 sclk_pos with bit 0 = 0, then 8 sclk_pos -> addr_we 1 cycle after the 8th edge; dm_we exactly 1 cycle after the 16th edge; miso_buff always 0; busy until CS high.
- Read: CS low, 8 sclk_pos with rw_bit=1 -> addr_we, then sr_we on the next cycle; miso_buff high from the cycle after sr_we until the 8th sclk_neg; DONE reached.
- Abort: CS high after 4 data edges of a write -> abort pulse 1 cycle, state IDLE, dm_we never asserted.
- Reset mid-read during READ_SHIFT -> next cycle all outputs 0 and busy=0; a new transaction then completes normally.
- Back-to-back: write then read with a single idle cycle between -> both complete; each has exactly one addr_we.
- SPI_TIMEOUT_EN with timeoutcycles=20: stop SCLK in WRITE_RECV -> abort after 20 cycles, no dm_we. Without the macro, the same stimulus leaves busy=1 indefinitely.
